board_engine_m: RTL

//  Clocked move-commit stage directly downstream of the player/AI move bus (update_loc, update_val, submit, reset).

---
 rtl/board_engine_m.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/board_engine_m.sv
// board_engine_m: move-commit stage for the 3x3 board.
// Catches each rising edge of submit, checks the move against the current
// turn and board, writes the cell, scores the board and passes the turn on.
// Every output comes straight from a flop.
module board_engine_m #(
    parameter logic       FIRST_TURN  = 1'b0,
    parameter logic [1:0] PLAYER_CELL = 2'b01
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  update_loc,
    input  logic [1:0]  update_val,
    input  logic        submit,
    input  logic        reset,
    output logic        turn,
    output logic [17:0] board,
    output logic [3:0]  move_count,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic        move_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_COMMIT,
        S_EVAL,
        S_HANDOVER
    } state_t;

    // The AI owns whichever piece the player does not.
    localparam logic [1:0] AI_CELL = PLAYER_CELL ^ 2'b11;

    state_t      state_q, state_d;
    logic        submit_q, submit_d;
    logic [3:0]  loc_q, loc_d;
    logic [1:0]  val_q, val_d;
    logic [17:0] board_q, board_d;
    logic [3:0]  count_q, count_d;
    logic [1:0]  winner_q, winner_d;
    logic        over_q, over_d;
    logic        turn_q, turn_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic        sub_edge;
    logic [1:0]  cell_cur;
    logic [1:0]  owner;
    logic [1:0]  line_win;
    logic        legal;

    // Returns the piece that fills cells a, b and c, or 00 if they differ.
    function automatic logic [1:0] line3(input logic [17:0] b, input int a,
                                         input int m, input int c);
        logic [1:0] pa;
        pa = b[2*a +: 2];
        if (pa != 2'b00 && pa == b[2*m +: 2] && pa == b[2*c +: 2])
            return pa;
        return 2'b00;
    endfunction

    // Returns the piece owning any complete row, column or diagonal.
    function automatic logic [1:0] find_win(input logic [17:0] b);
        logic [1:0] w;
        w = line3(b, 0, 1, 2);
        if (w == 2'b00) w = line3(b, 3, 4, 5);
        if (w == 2'b00) w = line3(b, 6, 7, 8);
        if (w == 2'b00) w = line3(b, 0, 3, 6);
        if (w == 2'b00) w = line3(b, 1, 4, 7);
        if (w == 2'b00) w = line3(b, 2, 5, 8);
        if (w == 2'b00) w = line3(b, 0, 4, 8);
        if (w == 2'b00) w = line3(b, 2, 4, 6);
        return w;
    endfunction

    // Find the latched cell's current contents and decide whether the move is legal.
    always_comb begin
        cell_cur = 2'b11;
        for (int i = 0; i < 9; i++) begin
            if (loc_q == i[3:0]) cell_cur = board_q[2*i +: 2];
        end
        owner    = turn_q ? AI_CELL : PLAYER_CELL;
        legal    = (loc_q <= 4'd8) && (val_q == owner) &&
                   (cell_cur == 2'b00) && !over_q;
        line_win = find_win(board_q);
    end

    // Next-state logic for the move sequencer and the game state.
    always_comb begin
        state_d  = state_q;
        submit_d = submit;
        loc_d    = loc_q;
        val_d    = val_q;
        board_d  = board_q;
        count_d  = count_q;
        winner_d = winner_q;
        over_d   = over_q;
        turn_d   = turn_q;
        err_d    = 1'b0;
        // A floating bus must not produce an edge, so insist on known 1 after known 0.
        sub_edge = (submit === 1'b1) && (submit_q === 1'b0);

        case (state_q)
            S_IDLE: begin
                if (sub_edge) begin
                    if (reset === 1'b1) begin
                        board_d  = '0;
                        count_d  = '0;
                        winner_d = 2'b00;
                        over_d   = 1'b0;
                        turn_d   = FIRST_TURN;
                    end else begin
                        loc_d   = update_loc;
                        val_d   = update_val;
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (legal) begin
                    state_d = S_COMMIT;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_COMMIT: begin
                for (int i = 0; i < 9; i++) begin
                    if (loc_q == i[3:0]) board_d[2*i +: 2] = val_q;
                end
                if (count_q != 4'd9) count_d = count_q + 4'd1;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (line_win != 2'b00) begin
                    winner_d = line_win;
                    over_d   = 1'b1;
                end else if (count_q == 4'd9) begin
                    winner_d = 2'b00;
                    over_d   = 1'b1;
                end
                state_d = S_HANDOVER;
            end
            S_HANDOVER: begin
                // After a finished game the player gets the bus to issue the reset.
                turn_d  = over_q ? 1'b0 : ~turn_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State registers; reset_n abandons any move in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            submit_q <= 1'b0;
            loc_q    <= '0;
            val_q    <= '0;
            board_q  <= '0;
            count_q  <= '0;
            winner_q <= 2'b00;
            over_q   <= 1'b0;
            turn_q   <= FIRST_TURN;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            submit_q <= submit_d;
            loc_q    <= loc_d;
            val_q    <= val_d;
            board_q  <= board_d;
            count_q  <= count_d;
            winner_q <= winner_d;
            over_q   <= over_d;
            turn_q   <= turn_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign turn       = turn_q;
    assign board      = board_q;
    assign move_count = count_q;
    assign winner     = winner_q;
    assign game_over  = over_q;
    assign move_err   = err_q;
    assign busy       = busy_q;

endmodule
